calc_cmd_sched: RTL

- Command scheduler in front of the calc datapath.
- Buffers 4-bit calculator commands from two requesters (key = source 0, host = source 1) in per-source FIFOs.
- Locks the calculator to one source per expression and issues one command per calc ready window using the calc status handshake.
- Detects calc error status and parks the system until reset.

---
 rtl/calc_pkg.sv | 16 +
 rtl/calc_cmd_fifo.sv | 46 ++++
 rtl/calc_cmd_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: calc status/command codes, scheduler state encoding and source index
// shared by the command scheduler and its FIFOs.
package calc_pkg;
    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [3:0] CMD_ADD  = 4'hA;
    localparam logic [3:0] CMD_SUB  = 4'hB;
    localparam logic [3:0] CMD_MUL  = 4'hC;
    localparam logic [3:0] CMD_EQ   = 4'hE;
    localparam logic [3:0] CMD_BKSP = 4'hF;
    typedef enum logic [1:0] {IDLE, WAIT_ACC, WAIT_RDY, ERROR} sched_state_t;
    typedef logic src_t;
    localparam src_t SRC_KEY  = 1'b0;
    localparam src_t SRC_HOST = 1'b1;
endpackage

// File: rtl/calc_cmd_fifo.sv
// calc_cmd_fifo: DEPTH x 4-bit command FIFO with synchronous flush; pushes while
// full and pops while empty are ignored.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [3:0]    data_i,
    output logic [3:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/calc_cmd_sched.sv
// calc_cmd_sched: two-source command scheduler with per-expression lock in front of calc.
// Optional watchdog enabled by defining CALC_SCHED_TIMEOUT_EN.
module calc_cmd_sched
    import calc_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] IDLE_CMD = 4'hD,
    parameter int         TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_cmd_i,
    input  logic       key_valid_i,
    output logic       key_ready_o,
    input  logic [3:0] host_cmd_i,
    input  logic       host_valid_i,
    output logic       host_ready_o,
    input  logic [1:0] calc_status_i,
    output logic [3:0] calc_cmd_o,
    output logic       owner_o,
    output logic       locked_o,
    output logic       busy_o,
    output logic       err_o,
    output logic       timeout_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    sched_state_t state_q, state_d;
    logic [3:0]   cmd_q, cmd_d;
    src_t         owner_q, owner_d, rr_q, rr_d, pick;
    logic         locked_q, locked_d, eq_q, eq_d, issue, to_hit;
    logic [3:0]   cmd_in [2];
    logic [3:0]   head [2];
    logic [CW-1:0] unused_count [2];
    logic [1:0]   valid, ready, push, pop, full, empty;
    assign cmd_in[0] = key_cmd_i;
    assign cmd_in[1] = host_cmd_i;
    assign valid = {host_valid_i, key_valid_i};
    assign ready = ~full & {2{state_q != ERROR}};
    assign push  = valid & ready;
    assign key_ready_o  = ready[0];
    assign host_ready_o = ready[1];
    for (genvar i = 0; i < 2; i++) begin : g_fifo
        calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .flush_i (state_q == ERROR),
            .data_i  (cmd_in[i]),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .count_o (unused_count[i])
        );
    end
    // Unlocked: take the preferred source if it has work, otherwise the other one.
    assign pick  = locked_q ? owner_q : (!empty[rr_q] ? rr_q : ~rr_q);
    assign issue = state_q == IDLE && calc_status_i == ST_READY && !empty[pick];
    assign pop   = {issue && pick == SRC_HOST, issue && pick == SRC_KEY};
`ifdef CALC_SCHED_TIMEOUT_EN
    logic [15:0] tcnt_q, tcnt_d;
    logic        timeout_q, waiting;
    assign waiting = state_q == WAIT_ACC || state_q == WAIT_RDY;
    assign to_hit  = waiting && tcnt_q == 16'(TIMEOUT - 1);
    assign tcnt_d  = (state_d != state_q || !waiting) ? '0 : tcnt_q + 16'd1;
    assign timeout_o = timeout_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= to_hit;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT != 0;
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        owner_d  = owner_q;
        locked_d = locked_q;
        rr_d     = rr_q;
        eq_d     = eq_q;
        if (calc_status_i == ST_ERR || to_hit || state_q == ERROR) begin
            state_d  = ERROR;
            cmd_d    = IDLE_CMD;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (issue) begin
                    state_d  = WAIT_ACC;
                    cmd_d    = head[pick];
                    eq_d     = head[pick] == CMD_EQ;
                    locked_d = 1'b1;
                    owner_d  = pick;
                end
                WAIT_ACC: if (calc_status_i == ST_BUSY) begin
                    state_d = WAIT_RDY;
                    cmd_d   = IDLE_CMD;
                end
                WAIT_RDY: if (calc_status_i == ST_READY) begin
                    state_d  = IDLE;
                    locked_d = eq_q ? 1'b0 : locked_q;
                    rr_d     = eq_q ? ~owner_q : rr_q;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= IDLE_CMD;
            owner_q  <= SRC_KEY;
            locked_q <= 1'b0;
            rr_q     <= SRC_KEY;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            rr_q     <= rr_d;
            eq_q     <= eq_d;
        end
    end
    assign calc_cmd_o = cmd_q;
    assign owner_o    = owner_q;
    assign locked_o   = locked_q;
    assign busy_o     = state_q != IDLE;
    assign err_o      = state_q == ERROR;
endmodule
